result_block_packer: RTL and testbench
======================================

// Module: result_block_packer
// PURPOSE
//  Downstream of the autotest control unit: takes one UUT result (cipher output + cycle count),
//  formats it into a 512-byte SD block and streams it byte-by-byte into the sdspihost write
//  port (w_block/w_byte/data_in/busy). Frees the control FSM from per-byte write sequencing.
// PARAMETERS
//  OUTPUT_SIZE_1  128   result width in bits; multiple of 8, 8..3968
//  BLOCK_BYTES    512   bytes per SD block
//  TIMEOUT        65535 max cycles waiting for any spi_busy edge before error
// PORTS
//  clk            in   1              system clock
//  rst            in   1              synchronous, active-high reset
//  start          in   1              1-cycle pulse: latch inputs, write one block
//  block_addr_in  in   32             SD block address to write
//  result_in      in   OUTPUT_SIZE_1  UUT output word
//  cycles_in      in   32             UUT latency in clk cycles
//  done           out  1              1-cycle pulse: block written OK
//  err            out  1              held high after failure until next accepted start
//  busy           out  1              high from accepted start until done/err
//  spi_busy       in   1              sdspihost busy
//  spi_err        in   1              sdspihost error
//  spi_block_addr out  32             address to sdspihost
//  spi_w_block    out  1              block-write request
//  spi_w_byte     out  1              byte strobe
//  spi_data_in    out  8              byte to host
// BEHAVIOUR
//  Clock and reset: one clock clk; reset rst is synchronous and active-high.
//  Reset: state IDLE, all outputs 0, byte counter 0, latched regs 0. Reset mid-write aborts
//   immediately; spi_w_block/spi_w_byte drop on the next edge.
//  Block layout (byte idx -> value):
//   0..3 = 0x54,0x57,0x46,0x53; 4..7 = cycles_in MSB first; 8..8+N-1 = result_in MSB first
//   (N = OUTPUT_SIZE_1/8); remaining bytes up to BLOCK_BYTES-1 = 0x00.
//   Byte counter is 10 bits. Byte mux is combinational from the latched regs.
//  FSM:
//   IDLE:   start=1 -> latch addr/result/cycles, clear err, busy=1, go to ARM.
//           start is ignored while busy=1.
//   ARM:    spi_w_block=1 (held through the whole block). spi_busy=1 -> WAIT_RDY.
//   WAIT_RDY: spi_busy=0 -> PUT.
//   PUT:    spi_data_in=byte[idx], spi_w_byte=1 for exactly 1 cycle -> WAIT_ACK.
//   WAIT_ACK: spi_busy=1 -> increment idx. If idx was BLOCK_BYTES-1 -> FINISH, else WAIT_RDY.
//   FINISH: deassert spi_w_block. Wait spi_busy=0 (CRC/programming) -> done=1 for 1 cycle,
//           busy=0 -> IDLE.
//   ERROR:  all spi_* strobes 0, err=1, busy=0. start -> IDLE-path (latch, ARM).
//  spi_data_in and spi_block_addr hold stable from PUT until the next PUT.
//  Timeout counter:
//   - resets on every state change;
//   - in ARM, WAIT_RDY, WAIT_ACK and FINISH, reaching TIMEOUT -> ERROR.
//  spi_err=1 in any non-IDLE state -> ERROR on the next edge (takes priority over all
//   other transitions).
//  Latency (ideal host that toggles spi_busy in 1 cycle): about 3 cycles per byte.
// TESTING
//  T1 reset: rst high 2 cycles mid-PUT -> next cycle all outputs 0, FSM IDLE, no w_byte.
//  T2 nominal: result=128'h00112233..FF, cycles=0x0000_0150, addr=0x20, host model 1-cycle busy
//     -> 512 w_byte pulses; bytes 0..7 = 54 57 46 53 00 00 01 50; bytes 8..23 = 00 11..FF;
//     bytes 24..511 = 00; done pulses once; spi_block_addr=0x20.
//  T3 slow host: busy held 100 cycles per byte -> identical byte stream; exactly 512 w_byte strobes.
//  T4 host error: spi_err=1 at byte 37 -> err=1 next cycle, strobes 0, no done;
//     new start -> err clears, full block written.
//  T5 timeout (TIMEOUT=16): spi_busy never rises after w_block -> err=1 at ARM entry+16 cycles.
//  T6 start while busy: second start at byte 10 ignored; exactly one done; latched data unchanged.

Source files
------------

// File: rtl/result_block_packer.sv
// Formats one UUT result into an SD block and streams it byte-by-byte into the
// sdspihost write port, handling the w_block/w_byte/busy handshake and timeouts.
module result_block_packer #(
  parameter int OUTPUT_SIZE_1 = 128,
  parameter int BLOCK_BYTES   = 512,
  parameter int TIMEOUT       = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              block_addr_in,
  input  logic [OUTPUT_SIZE_1-1:0] result_in,
  input  logic [31:0]              cycles_in,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  input  logic                     spi_busy,
  input  logic                     spi_err,
  output logic [31:0]              spi_block_addr,
  output logic                     spi_w_block,
  output logic                     spi_w_byte,
  output logic [7:0]               spi_data_in
);
  localparam int N_RES = OUTPUT_SIZE_1 / 8;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [9:0]  RES_END  = 10'(8 + N_RES);
  localparam logic [9:0]  LAST_IDX = 10'(BLOCK_BYTES - 1);
  localparam logic [31:0] MAGIC    = 32'h5457_4653;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_RDY, S_PUT, S_WAIT_ACK, S_FINISH, S_ERROR
  } state_t;

  state_t                   state;
  logic [9:0]               byte_idx;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [OUTPUT_SIZE_1-1:0] result_q;
  logic [31:0]              cycles_q;

  logic [9:0]               res_idx;
  logic [31:0]              mag_shift;
  logic [31:0]              cyc_shift;
  logic [OUTPUT_SIZE_1-1:0] res_shift;
  logic [7:0]               byte_mux;
  logic                     timed;
  logic                     advance;
  logic                     to_error;

  // Each field is shifted so the wanted byte lands at the top (MSB-first order).
  assign res_idx   = byte_idx - 10'd8;
  assign mag_shift = MAGIC << {byte_idx[1:0], 3'b000};
  assign cyc_shift = cycles_q << {byte_idx[1:0], 3'b000};
  assign res_shift = result_q << {res_idx, 3'b000};

  always_comb begin
    byte_mux = 8'h00;
    if (byte_idx < 10'd4)      byte_mux = mag_shift[31:24];
    else if (byte_idx < 10'd8) byte_mux = cyc_shift[31:24];
    else if (byte_idx < RES_END) byte_mux = res_shift[OUTPUT_SIZE_1-1 -: 8];
  end

  always_comb begin
    timed   = (state == S_ARM) || (state == S_WAIT_RDY) ||
              (state == S_WAIT_ACK) || (state == S_FINISH);
    advance = ((state == S_ARM)      &&  spi_busy) ||
              ((state == S_WAIT_RDY) && !spi_busy) ||
              ((state == S_WAIT_ACK) &&  spi_busy) ||
              ((state == S_FINISH)   && !spi_busy);
    to_error = ((state != S_IDLE) && spi_err) || (timed && !advance && (tmo_cnt == TMO_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      byte_idx       <= '0;
      tmo_cnt        <= '0;
      result_q       <= '0;
      cycles_q       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
      spi_block_addr <= '0;
      spi_w_block    <= 1'b0;
      spi_w_byte     <= 1'b0;
      spi_data_in    <= '0;
    end else begin
      done       <= 1'b0;
      spi_w_byte <= 1'b0;
      // The timeout only runs while parked in a wait state; any move clears it.
      if (timed && !advance) tmo_cnt <= tmo_cnt + TMO_ONE;
      else                   tmo_cnt <= '0;

      if (to_error) begin
        state       <= S_ERROR;
        err         <= 1'b1;
        busy        <= 1'b0;
        spi_w_block <= 1'b0;
        byte_idx    <= '0;
        tmo_cnt     <= '0;
      end else begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (start) begin
              spi_block_addr <= block_addr_in;
              result_q       <= result_in;
              cycles_q       <= cycles_in;
              err            <= 1'b0;
              busy           <= 1'b1;
              spi_w_block    <= 1'b1;
              byte_idx       <= '0;
              state          <= S_ARM;
            end
          end
          S_ARM: if (spi_busy) state <= S_WAIT_RDY;
          S_WAIT_RDY: begin
            if (!spi_busy) begin
              spi_w_byte  <= 1'b1;
              spi_data_in <= byte_mux;
              state       <= S_PUT;
            end
          end
          S_PUT: state <= S_WAIT_ACK;
          S_WAIT_ACK: begin
            if (spi_busy) begin
              if (byte_idx == LAST_IDX) begin
                spi_w_block <= 1'b0;
                byte_idx    <= '0;
                state       <= S_FINISH;
              end else begin
                byte_idx <= byte_idx + 10'd1;
                state    <= S_WAIT_RDY;
              end
            end
          end
          S_FINISH: begin
            if (!spi_busy) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_result_block_packer.sv
// Bench for result_block_packer: host model drives the busy handshake, a block
// model built from the layout rules is checked against every byte strobe.
module tb_result_block_packer;
  localparam int OW = 128;
  localparam int BB = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, spi_busy, spi_err;
  logic [31:0]   block_addr_in, cycles_in;
  logic [OW-1:0] result_in;
  logic          done, err, busy, spi_w_block, spi_w_byte;
  logic [31:0]   spi_block_addr;
  logic [7:0]    spi_data_in;

  logic          rst_t, start_t, spi_busy_t, spi_err_t;
  logic          done_t, err_t, busy_t, spi_w_block_t, spi_w_byte_t;
  logic [31:0]   spi_block_addr_t;
  logic [7:0]    spi_data_in_t;

  result_block_packer #(.OUTPUT_SIZE_1(OW), .BLOCK_BYTES(BB), .TIMEOUT(65535)) dut (
    .clk(clk), .rst(rst), .start(start), .block_addr_in(block_addr_in),
    .result_in(result_in), .cycles_in(cycles_in), .done(done), .err(err), .busy(busy),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_block_addr(spi_block_addr),
    .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte), .spi_data_in(spi_data_in));

  result_block_packer #(.OUTPUT_SIZE_1(OW), .BLOCK_BYTES(BB), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst_t), .start(start_t), .block_addr_in(32'h0000_0077),
    .result_in(result_in), .cycles_in(cycles_in), .done(done_t), .err(err_t), .busy(busy_t),
    .spi_busy(spi_busy_t), .spi_err(spi_err_t), .spi_block_addr(spi_block_addr_t),
    .spi_w_block(spi_w_block_t), .spi_w_byte(spi_w_byte_t), .spi_data_in(spi_data_in_t));

  int tests = 0;
  int fails = 0;
  logic [7:0]  exp_blk [BB];
  logic [31:0] exp_addr;
  int strobe_cnt, done_cnt, host_delay, busy_left;
  bit blk_seen;

  localparam logic [OW-1:0] RES_A = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [OW-1:0] RES_B = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F0E1_D2C3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected block straight from the layout: magic, cycles, result, zero fill.
  function automatic void build_block(input logic [OW-1:0] res, input logic [31:0] cyc);
    logic [31:0] magic;
    magic = 32'h5457_4653;
    for (int i = 0; i < BB; i++) exp_blk[i] = 8'h00;
    for (int i = 0; i < 4; i++) exp_blk[i]     = 8'(magic >> (8 * (3 - i)));
    for (int i = 0; i < 4; i++) exp_blk[4 + i] = 8'(cyc >> (8 * (3 - i)));
    for (int i = 0; i < OW / 8; i++) exp_blk[8 + i] = 8'(res >> (8 * (OW / 8 - 1 - i)));
  endfunction

  // Host: acks w_block with a 1-cycle busy, each byte with host_delay busy cycles.
  initial begin
    spi_busy = 1'b0; busy_left = 0; blk_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        spi_busy = 1'b0; busy_left = 0; blk_seen = 1'b0;
      end else begin
        if (busy_left > 0) begin spi_busy = 1'b1; busy_left--; end
        else spi_busy = 1'b0;
        if (spi_w_block && !blk_seen) begin blk_seen = 1'b1; busy_left = 1; end
        if (!spi_w_block) blk_seen = 1'b0;
        if (spi_w_byte) busy_left = host_delay;
      end
    end
  end

  // Compare process: every strobed byte against the model, done accounting.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (spi_w_byte) begin
          if (strobe_cnt < BB)
            check($sformatf("byte%0d", strobe_cnt), 64'(spi_data_in), 64'(exp_blk[strobe_cnt]));
          else
            check("extra_strobe", 64'(strobe_cnt), 64'(BB - 1));
          check("addr_at_strobe", 64'(spi_block_addr), 64'(exp_addr));
          check("wblock_at_strobe", 64'(spi_w_block), 64'd1);
          strobe_cnt++;
        end
        if (done) begin
          done_cnt++;
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  task automatic start_block(input logic [31:0] addr, input logic [OW-1:0] res,
                             input logic [31:0] cyc, input int delay);
    build_block(res, cyc);
    exp_addr = addr; host_delay = delay; strobe_cnt = 0; done_cnt = 0;
    block_addr_in = addr; result_in = res; cycles_in = cyc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_after_start", 64'(err), 64'd0);
  endtask

  task automatic run_block(input logic [31:0] addr, input logic [OW-1:0] res,
                           input logic [31:0] cyc, input int delay, input int poke_at,
                           input int budget);
    bit poked;
    poked = 1'b0;
    start_block(addr, res, cyc, delay);
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!poked && poke_at >= 0 && strobe_cnt >= poke_at) begin
        poked = 1'b1; start = 1'b1;
        block_addr_in = ~addr; result_in = ~res; cycles_in = ~cyc;
      end
    end
    start = 1'b0;
    check("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("strobe_total", 64'(strobe_cnt), 64'(BB));
    check("busy_idle", 64'(busy), 64'd0);
    check("err_idle", 64'(err), 64'd0);
    check("wblock_idle", 64'(spi_w_block), 64'd0);
    check("addr_hold", 64'(spi_block_addr), 64'(addr));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spi_err = 1'b0;
    block_addr_in = '0; result_in = '0; cycles_in = '0;
    host_delay = 1; strobe_cnt = 0; done_cnt = 0; exp_addr = '0;
    rst_t = 1'b1; start_t = 1'b0; spi_busy_t = 1'b0; spi_err_t = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wblock", 64'(spi_w_block), 64'd0);
    check("rst_wbyte", 64'(spi_w_byte), 64'd0);
    check("rst_addr", 64'(spi_block_addr), 64'd0);
    check("rst_data", 64'(spi_data_in), 64'd0);
    rst = 1'b0; rst_t = 1'b0;
    @(negedge clk);

    // Model pins for the nominal block.
    build_block(RES_A, 32'h0000_0150);
    check("model_b0", 64'(exp_blk[0]), 64'h54);
    check("model_b3", 64'(exp_blk[3]), 64'h53);
    check("model_b6", 64'(exp_blk[6]), 64'h01);
    check("model_b7", 64'(exp_blk[7]), 64'h50);
    check("model_b9", 64'(exp_blk[9]), 64'h11);
    check("model_b23", 64'(exp_blk[23]), 64'hFF);
    check("model_b24", 64'(exp_blk[24]), 64'h00);

    // Reset asserted in the middle of a byte put.
    start_block(32'h0000_0020, RES_A, 32'h0000_0150, 1);
    for (int c = 0; c < 200 && !(spi_w_byte && strobe_cnt >= 5); c++) @(negedge clk);
    check("t1_in_put", 64'(spi_w_byte), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t1_wbyte", 64'(spi_w_byte), 64'd0);
    check("t1_wblock", 64'(spi_w_block), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_addr", 64'(spi_block_addr), 64'd0);
    check("t1_data", 64'(spi_data_in), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_post_wbyte", 64'(spi_w_byte), 64'd0);
    check("t1_post_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Nominal block, fast host.
    run_block(32'h0000_0020, RES_A, 32'h0000_0150, 1, -1, 3000);

    // Slow host: 100 busy cycles per byte.
    run_block(32'h0000_0020, RES_A, 32'h0000_0150, 100, -1, 60000);

    // Host error at byte 37, then recovery on a fresh start.
    start_block(32'h0000_0040, RES_B, 32'hCAFE_0001, 1);
    for (int c = 0; c < 400 && strobe_cnt < 38; c++) @(negedge clk);
    spi_err = 1'b1;
    @(negedge clk);
    spi_err = 1'b0;
    check("t4_err", 64'(err), 64'd1);
    check("t4_wblock", 64'(spi_w_block), 64'd0);
    check("t4_wbyte", 64'(spi_w_byte), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("t4_err_held", 64'(err), 64'd1);
    check("t4_no_done", 64'(done_cnt), 64'd0);
    check("t4_strobes", 64'(strobe_cnt), 64'd38);
    run_block(32'h0000_0041, RES_B, 32'hCAFE_0001, 1, -1, 3000);

    // Second start mid-block must be ignored.
    run_block(32'h0000_1234, RES_B, 32'h0000_00AB, 1, 10, 3000);

    // Timeout: host never answers w_block.
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("t5_wblock", 64'(spi_w_block_t), 64'd1);
    check("t5_addr", 64'(spi_block_addr_t), 64'h77);
    repeat (15) @(negedge clk);
    check("t5_err_early", 64'(err_t), 64'd0);
    @(negedge clk);
    check("t5_err", 64'(err_t), 64'd1);
    check("t5_wblock_off", 64'(spi_w_block_t), 64'd0);
    check("t5_busy_off", 64'(busy_t), 64'd0);
    check("t5_no_done", 64'(done_t), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
